// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size codes used by both the
// LSU and load_extend, the LSU state encoding, and an alignment helper.
package lsu_pkg;

    // Size codes shared with load_extend (stores only use B, H and W)
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b011;
    localparam logic [2:0] SZ_HU = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } lsu_state_t;

    // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes always fit.
    function automatic logic is_misaligned(input logic [2:0] sel, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (sel)
            SZ_H, SZ_HU: mis = lo[0];
            SZ_W:        mis = (lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // A full-word store needs no read; everything narrower is read-modify-write.
    function automatic logic is_word(input logic [2:0] sel);
        return (sel == SZ_W);
    endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational byte/half insertion of right-aligned store data into an
// existing memory word. The memory has no byte enables, so narrow stores
// are built here from the word read back beforehand.
module store_merge
    import lsu_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [2:0]  sel,
    input  logic [1:0]  addr_lo,
    output logic [31:0] merged
);

    // Overwrite only the addressed lane(s); all other bits pass through
    always_comb begin
        merged = old_word;
        case (sel)
            SZ_B, SZ_BU: begin
                case (addr_lo)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SZ_H, SZ_HU: begin
                if (addr_lo[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            SZ_W:    merged = wdata;
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the CPU and a single-port word-wide synchronous
// memory without byte enables. One access at a time; the CPU is stalled
// while an access is in flight. Loads return the raw aligned word plus the
// original byte address so load_extend can select and extend the lane.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_sel,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    // Counter reload: WAIT lasts MEM_LAT cycles, the last one latching data
    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    lsu_state_t  state;
    logic [1:0]  cnt;
    logic        cap_we;
    logic [2:0]  cap_sel;
    logic [31:0] cap_wdata;
    logic [31:0] merged_word;
    logic        accept;

    assign accept = (state == ST_IDLE) && req_valid;

    // Combinational so the CPU is already held in the accept cycle
    assign stall = accept || (state == ST_RD) || (state == ST_WAIT) || (state == ST_WR);

    // Merge store data into the word as it arrives from memory
    store_merge u_merge (
        .old_word (mem_rdata),
        .wdata    (cap_wdata),
        .sel      (cap_sel),
        .addr_lo  (rsp_addr[1:0]),
        .merged   (merged_word)
    );

    // Capture the request attributes that steer the rest of the access
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_we    <= req_we;
            cap_sel   <= req_sel;
            cap_wdata <= req_wdata;
        end
    end

    // Access sequencer with registered strobes and response outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= 2'd0;
            rsp_valid <= 1'b0;
            misalign  <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_addr  <= '0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
        end else begin
            rsp_valid <= 1'b0;
            misalign  <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        rsp_addr <= req_addr;
                        mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                        if (is_misaligned(req_sel, req_addr[1:0])) begin
                            // Rejected without touching memory
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            misalign  <= 1'b1;
                        end else if (req_we && is_word(req_sel)) begin
                            state     <= ST_WR;
                            mem_we    <= 1'b1;
                            mem_wdata <= req_wdata;
                        end else begin
                            state  <= ST_RD;
                            mem_re <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    state <= ST_WAIT;
                    cnt   <= CNT_INIT;
                end
                ST_WAIT: begin
                    if (cnt != 2'd0) begin
                        cnt <= cnt - 2'd1;
                    end else begin
                        // Stores keep the pre-merge word visible on rsp_rdata
                        rsp_rdata <= mem_rdata;
                        if (cap_we) begin
                            state     <= ST_WR;
                            mem_we    <= 1'b1;
                            mem_wdata <= merged_word;
                        end else begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                end
                ST_RESP: begin
                    // The CPU still presents the finished instruction here
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: two instances (MEM_LAT 1 and 3) with a
// word memory model each; expected responses are queued when a request is
// driven and compared when rsp_valid appears.
module tb_dmem_lsu;

    localparam int AW   = 32;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]           reset_n, req_valid, req_we, stall, rsp_valid, misalign, mem_re, mem_we;
    logic [1:0][2:0]      req_sel;
    logic [1:0][AW-1:0]   req_addr, rsp_addr, mem_addr;
    logic [1:0][31:0]     req_wdata, rsp_rdata, mem_wdata, mem_rdata;

    dmem_lsu #(.MEM_LAT(LAT0), .ADDR_W(AW)) u_dut0 (
        .clk(clk), .reset_n(reset_n[0]), .req_valid(req_valid[0]), .req_we(req_we[0]),
        .req_sel(req_sel[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .stall(stall[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_addr(rsp_addr[0]), .misalign(misalign[0]), .mem_addr(mem_addr[0]),
        .mem_re(mem_re[0]), .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0])
    );

    dmem_lsu #(.MEM_LAT(LAT1), .ADDR_W(AW)) u_dut1 (
        .clk(clk), .reset_n(reset_n[1]), .req_valid(req_valid[1]), .req_we(req_we[1]),
        .req_sel(req_sel[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .stall(stall[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_addr(rsp_addr[1]), .misalign(misalign[1]), .mem_addr(mem_addr[1]),
        .mem_re(mem_re[1]), .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1])
    );

    // Memory model: read data valid exactly LAT cycles after mem_re, garbage otherwise
    logic [31:0] mem     [2][64];
    logic [31:0] rd_pipe [2][4];
    logic        poke_en = 1'b0;
    int          poke_i  = 0;
    logic [5:0]  poke_a  = '0;
    logic [31:0] poke_d  = '0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 3; j > 0; j--) rd_pipe[i][j] <= rd_pipe[i][j-1];
            rd_pipe[i][0] <= mem_re[i] ? mem[i][mem_addr[i][7:2]] : 32'hDEAD_BEEF;
            if (mem_we[i]) mem[i][mem_addr[i][7:2]] <= mem_wdata[i];
        end
        if (poke_en) mem[poke_i][poke_a] <= poke_d;
    end

    always_comb begin
        mem_rdata[0] = rd_pipe[0][LAT0-1];
        mem_rdata[1] = rd_pipe[1][LAT1-1];
    end

    typedef struct {
        logic [31:0]   rdata;
        logic [AW-1:0] addr;
        logic          mis;
        int            lat;
        int            n_re;
        int            n_we;
        logic [31:0]   wword;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mdl [2][64];
    logic [31:0] last_rdata [2];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    // Independent reference merge using shifted masks
    function automatic logic [31:0] merge_model(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [2:0] sel, input logic [1:0] lo);
        logic [31:0] mask;
        int          sh;
        if (sel == 3'd0 || sel == 3'd3) begin
            mask = 32'h0000_00FF;
            sh   = 8 * int'(lo);
        end else if (sel == 3'd1 || sel == 3'd4) begin
            mask = 32'h0000_FFFF;
            sh   = lo[1] ? 16 : 0;
        end else begin
            return wd;
        end
        return (old & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    task automatic poke(input int i, input logic [31:0] byte_addr, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_i = i; poke_a = byte_addr[7:2]; poke_d = d;
        mdl[i][byte_addr[7:2]] = d;
        @(posedge clk);
        #1 poke_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int i);
        req_valid[i] = 1'b0;
        @(negedge clk);
    endtask

    // Drive one request (called at a negedge), push its expectation, follow it to rsp_valid
    task automatic do_req(input int i, input logic we, input logic [2:0] sel,
                          input logic [31:0] addr, input logic [31:0] wd, input bit b2b);
        exp_t        e, f;
        logic [31:0] old;
        int          n_re, n_we;
        bit          got;
        e.mis   = (sel == 3'd1 || sel == 3'd4) ? addr[0] : (sel == 3'd2) ? (addr[1:0] != 2'b00) : 1'b0;
        old     = mdl[i][addr[7:2]];
        e.addr  = addr;
        e.n_re  = 0;
        e.n_we  = 0;
        e.wword = 32'd0;
        e.rdata = last_rdata[i];
        if (e.mis) begin
            e.lat = 1;
        end else if (we && sel == 3'd2) begin
            e.lat = 2; e.n_we = 1; e.wword = wd;
        end else begin
            e.n_re = 1; e.rdata = old; e.lat = lat_of(i) + 2;
            if (we) begin
                e.lat = e.lat + 1; e.n_we = 1;
                e.wword = merge_model(old, wd, sel, addr[1:0]);
            end
        end
        if (e.n_we != 0) mdl[i][addr[7:2]] = e.wword;
        last_rdata[i] = e.rdata;
        exp_q.push_back(e);

        req_we[i] = we; req_sel[i] = sel; req_addr[i] = addr; req_wdata[i] = wd;
        req_valid[i] = 1'b1;
        #1;
        if (b2b) begin
            chk("no_accept_in_resp", {31'd0, stall[i]}, 32'd0);
            @(negedge clk);
            #1;
        end
        chk("stall_accept", {31'd0, stall[i]}, 32'd1);
        n_re = 0; n_we = 0; got = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_re[i] && mem_we[i]) chk("re_we_overlap", 32'd1, 32'd0);
            if (mem_re[i]) begin
                n_re++;
                chk("re_cycle", c, 1);
                chk("mem_addr_rd", mem_addr[i], {addr[31:2], 2'b00});
            end
            if (mem_we[i]) begin
                n_we++;
                chk("we_cycle", c, exp_q[0].lat - 1);
                chk("mem_addr_wr", mem_addr[i], {addr[31:2], 2'b00});
                chk("mem_wdata", mem_wdata[i], exp_q[0].wword);
            end
            if (rsp_valid[i]) begin
                got = 1;
                f = exp_q.pop_front();
                chk("rsp_latency", c, f.lat);
                chk("rsp_rdata", rsp_rdata[i], f.rdata);
                chk("rsp_addr", rsp_addr[i], f.addr);
                chk("misalign", {31'd0, misalign[i]}, {31'd0, f.mis});
                chk("stall_in_resp", {31'd0, stall[i]}, 32'd0);
                chk("n_mem_re", n_re, f.n_re);
                chk("n_mem_we", n_we, f.n_we);
                break;
            end else if (!stall[i]) begin
                chk("stall_dropped_early", 32'd0, 32'd1);
            end
        end
        if (!got) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic chk_zero(input int i, input string tag);
        chk({tag, "_stall"},     {31'd0, stall[i]},     32'd0);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid[i]}, 32'd0);
        chk({tag, "_misalign"},  {31'd0, misalign[i]},  32'd0);
        chk({tag, "_mem_re"},    {31'd0, mem_re[i]},    32'd0);
        chk({tag, "_mem_we"},    {31'd0, mem_we[i]},    32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata[i],          32'd0);
        chk({tag, "_rsp_addr"},  rsp_addr[i],           32'd0);
        chk({tag, "_mem_addr"},  mem_addr[i],           32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata[i],          32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_seen;
        reset_n = 2'b00; req_valid = 2'b00; req_we = 2'b00;
        req_sel = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 2; i++) begin
            last_rdata[i] = 32'd0;
            for (int a = 0; a < 64; a++) begin
                mdl[i][a] = 32'h0101_0101 * a;
                mem[i][a] = 32'h0101_0101 * a;
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");
        reset_n = 2'b11;
        @(negedge clk);

        // MEM_LAT = 1 instance
        poke(0, 32'h10, 32'hA1B2_C3D4);
        do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 0);
        chk("load_word_value", rsp_rdata[0], 32'hA1B2_C3D4);
        idle(0);
        poke(0, 32'h20, 32'h1122_3344);
        do_req(0, 1'b1, 3'b000, 32'h22, 32'h0000_00EE, 0);
        idle(0);
        chk("sb_mem_word", mem[0][8], 32'h11EE_3344);
        poke(0, 32'h20, 32'h1122_3344);
        do_req(0, 1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 0);
        idle(0);
        chk("sh_upper_mem_word", mem[0][8], 32'hBEEF_3344);
        do_req(0, 1'b0, 3'b010, 32'h13, 32'h0, 0);
        idle(0);
        do_req(0, 1'b0, 3'b100, 32'h21, 32'h0, 0);
        idle(0);
        do_req(0, 1'b1, 3'b001, 32'h23, 32'h1234, 0);
        idle(0);
        do_req(0, 1'b0, 3'b011, 32'h23, 32'h0, 0);
        idle(0);
        do_req(0, 1'b1, 3'b001, 32'h20, 32'h0000_5A5A, 0);
        idle(0);
        do_req(0, 1'b1, 3'b000, 32'h21, 32'hFFFF_FF77, 0);
        do_req(0, 1'b1, 3'b000, 32'h24, 32'h0000_0066, 1);
        idle(0);
        do_req(0, 1'b1, 3'b010, 32'h28, 32'h0BAD_F00D, 0);
        idle(0);
        for (int a = 8; a < 11; a++) chk("mem0_final", mem[0][a], mdl[0][a]);

        // MEM_LAT = 3 instance, back-to-back load then word store
        poke(1, 32'h30, 32'hCAFE_F00D);
        do_req(1, 1'b0, 3'b010, 32'h30, 32'h0, 0);
        do_req(1, 1'b1, 3'b010, 32'h34, 32'h1234_5678, 1);
        idle(1);
        chk("b2b_store_mem", mem[1][13], 32'h1234_5678);
        do_req(1, 1'b1, 3'b001, 32'h30, 32'h0000_9876, 0);
        idle(1);
        chk("sh_lat3_mem", mem[1][12], 32'hCAFE_9876);

        // Reset during WAIT of a byte store on the MEM_LAT = 3 instance
        poke(1, 32'h40, 32'h5566_7788);
        req_we[1] = 1'b1; req_sel[1] = 3'b000; req_addr[1] = 32'h41; req_wdata[1] = 32'h99;
        req_valid[1] = 1'b1;
        we_seen = 0;
        @(negedge clk);
        @(negedge clk);
        if (mem_we[1]) we_seen++;
        reset_n[1] = 1'b0;
        req_valid[1] = 1'b0;
        @(negedge clk);
        if (mem_we[1]) we_seen++;
        chk_zero(1, "midreset");
        reset_n[1] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (mem_we[1]) we_seen++;
        end
        chk("midreset_no_write", we_seen, 0);
        chk("midreset_mem_kept", mem[1][16], 32'h5566_7788);
        last_rdata[1] = 32'd0;
        do_req(1, 1'b0, 3'b000, 32'h41, 32'h0, 0);
        idle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
